// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Arbitrates one shared memory bus between an instruction-fetch port and a
//   load/store port. The load/store port has fixed priority. Each access runs
//   IDLE -> BUSY -> DONE, so there is at most one access every three cycles.
//   A wait counter aborts an access that gets no ack within TIMEOUT cycles.
//   A jump flush discards a fetch result that is pending or still in flight.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   if_req_i, if_addr_i          fetch request, held until if_valid_o
//   mem_req_i, mem_we_i,
//   mem_addr_i, mem_wdata_i      load/store request, held until mem_valid_o
//   flush_i                      jump flush, discards fetch results
//   bus_req_o, bus_we_o,
//   bus_addr_o, bus_wdata_o      registered shared bus request
//   bus_ack_i, bus_rdata_i       bus completion, read data valid with ack
//   if_valid_o, if_rdata_o       fetch completion pulse and data
//   mem_valid_o, mem_rdata_o     load/store completion pulse and data
//   stallreq_from_if_o,
//   stallreq_from_mem_o          stall requests to the pipeline controller
//   err_o                        one-cycle pulse on bus timeout
module mem_port_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic                  flush_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  stallreq_from_if_o,
  output logic                  stallreq_from_mem_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;

  // Counter value at which an access without ack is aborted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic                  discard_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic                  if_vld_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic                  mem_vld_q;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_vld_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_vld_q   <= 1'b0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // Completion and error flags are single-cycle pulses.
      if_vld_q  <= 1'b0;
      mem_vld_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req_i) begin
            state_q     <= MEM_BUSY;
            cnt_q       <= '0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we_i;
            bus_addr_q  <= mem_addr_i;
            bus_wdata_q <= mem_wdata_i;
          end else if (if_req_i && !flush_i) begin
            state_q     <= IF_BUSY;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_addr_i;
            bus_wdata_q <= '0;
          end
        end
        IF_BUSY: begin
          if (bus_ack_i) begin
            // Bus cycle always completes; only the result is dropped on flush.
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            discard_q <= 1'b0;
            if (!(discard_q || flush_i)) begin
              if_vld_q   <= 1'b1;
              if_rdata_q <= bus_rdata_i;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            discard_q <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (flush_i) discard_q <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (bus_ack_i) begin
            state_q     <= DONE;
            bus_req_q   <= 1'b0;
            mem_vld_q   <= 1'b1;
            mem_rdata_q <= bus_rdata_i;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          // DONE: one dead cycle, no grant, late acks ignored.
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  // A flush arriving in the DONE cycle still cancels the fetch completion.
  assign if_valid_o  = if_vld_q & ~flush_i;
  assign if_rdata_o  = if_rdata_q;
  assign mem_valid_o = mem_vld_q;
  assign mem_rdata_o = mem_rdata_q;
  assign err_o       = err_q;

  assign stallreq_from_if_o  = if_req_i & ~if_valid_o;
  assign stallreq_from_mem_o = mem_req_i & ~mem_valid_o;

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          flush = 1'b0;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          if_valid, mem_valid, stall_if, stall_mem, err;
  logic [DW-1:0] if_rdata, mem_rdata;

  int total = 0;
  int passed = 0;
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] mem_exp_q[$];
  int err_exp = 0;

  mem_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .flush_i(flush),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .mem_valid_o(mem_valid), .mem_rdata_o(mem_rdata),
    .stallreq_from_if_o(stall_if), .stallreq_from_mem_o(stall_mem),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pops an expectation every time the DUT presents a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid) begin
        if (if_exp_q.size() == 0) check("if_valid_unexpected", 1, 0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (mem_valid) begin
        if (mem_exp_q.size() == 0) check("mem_valid_unexpected", 1, 0);
        else check("mem_rdata", mem_rdata, mem_exp_q.pop_front());
      end
      if (err) begin
        check("err_expected", (err_exp > 0), 1);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  // Leaves the caller at the negedge of the first cycle with bus_req_o high.
  task automatic wait_bus_req(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus_req) check({nm, "_bus_req_timeout"}, 0, 1);
  endtask

  // Called at the negedge of bus cycle 1; acks in bus cycle 1+n, returns in DONE.
  task automatic ack_after(input int n, input logic [DW-1:0] d);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b1;
    bus_rdata = d;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset state
    @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_valids", {if_valid, mem_valid, err}, 0);
    check("rst_rdata", {if_rdata, mem_rdata}, 0);
    check("rst_bus_addr", bus_addr, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Plain fetch, ack in third bus cycle
    if_exp_q.push_back(32'h0000_0013);
    if_req = 1'b1; if_addr = 32'h100;
    wait_bus_req("fetch");
    check("fetch_addr", bus_addr, 32'h100);
    check("fetch_we_wdata", {bus_we, bus_wdata}, 0);
    check("fetch_stall", stall_if, 1);
    ack_after(2, 32'h0000_0013);
    @(negedge clk);
    check("fetch_valid_after_ack", if_valid, 1);
    check("fetch_bus_req_dropped", bus_req, 0);
    check("fetch_stall_released", stall_if, 0);
    @(posedge clk); #1 if_req = 1'b0;

    // Contention: store wins, fetch granted in the cycle after DONE
    mem_exp_q.push_back(32'h0);
    if_exp_q.push_back(32'hAABB_CCDD);
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
    wait_bus_req("store");
    check("store_addr", bus_addr, 32'h2000);
    check("store_we", bus_we, 1);
    check("store_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("store_stall_if", stall_if, 1);
    check("store_stall_mem", stall_mem, 1);
    ack_after(0, 32'h0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("store_done_valid", mem_valid, 1);
    check("cont_stall_if_done", stall_if, 1);
    @(negedge clk);
    check("cont_idle_bus_req", bus_req, 0);
    check("cont_stall_if_idle", stall_if, 1);
    @(negedge clk);
    check("cont_fetch_granted", bus_req, 1);
    check("cont_fetch_addr", bus_addr, 32'h104);
    check("cont_fetch_we", bus_we, 0);
    ack_after(1, 32'hAABB_CCDD);
    @(posedge clk); #1 if_req = 1'b0;

    // Flush during IF_BUSY, ack two cycles later: no completion
    if_req = 1'b1; if_addr = 32'h200;
    wait_bus_req("flush");
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    ack_after(1, 32'h1111_2222);
    if_req = 1'b0;
    @(negedge clk);
    check("flush_no_valid", if_valid, 0);
    check("flush_done_bus_req", bus_req, 0);
    check("flush_no_err", err, 0);
    @(negedge clk);
    check("flush_idle_bus_req", bus_req, 0);
    check("flush_rdata_held", if_rdata, 32'hAABB_CCDD);

    // Flush in the DONE cycle cancels the completion
    if_req = 1'b1; if_addr = 32'h500;
    wait_bus_req("flushdone");
    ack_after(0, 32'h3333_4444);
    flush = 1'b1;
    @(negedge clk);
    check("flushdone_no_valid", if_valid, 0);
    @(posedge clk); #1 flush = 1'b0; if_req = 1'b0;

    // Timeout with TIMEOUT=4, then regrant and ack on the final allowed cycle
    err_exp = 1;
    mem_exp_q.push_back(32'h0000_0055);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    wait_bus_req("timeout");
    cnt = 0;
    while (bus_req && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_bus_req_cycles", cnt, 4);
    check("timeout_err_pulse", err, 1);
    check("timeout_no_valid", mem_valid, 0);
    @(negedge clk);
    check("timeout_regrant", bus_req, 1);
    check("timeout_err_cleared", err, 0);
    ack_after(3, 32'h0000_0055);
    mem_req = 1'b0;
    @(negedge clk);
    check("lastcycle_ack_valid", mem_valid, 1);
    check("lastcycle_ack_no_err", err, 0);
    check("timeout_err_consumed", err_exp, 0);

    // Reset mid MEM_BUSY drops bus_req asynchronously; late ack ignored
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h1234_5678;
    wait_bus_req("rstmid");
    #2 rst = 1'b1;
    #1;
    check("rst_async_bus_req", bus_req, 0);
    check("rst_async_rdata", mem_rdata, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(posedge clk); #1 bus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_no_valid", {if_valid, mem_valid, err}, 0);
    check("late_ack_bus_req", bus_req, 0);
    check("late_ack_rdata_kept", mem_rdata, 0);

    repeat (3) @(negedge clk);
    check("if_queue_empty", if_exp_q.size(), 0);
    check("mem_queue_empty", mem_exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all data ports.
REQ-003 Parameter TIMEOUT, default 16, maximum bus wait in cycles before abort; range 2..255.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 if_req_i / if_addr_i  in  1 / ADDR_WIDTH  instruction-fetch request, held until if_valid_o.
REQ-007 mem_req_i / mem_we_i / mem_addr_i / mem_wdata_i  in  1 / 1 / ADDR_WIDTH / DATA_WIDTH  load/store request, held until mem_valid_o.
REQ-008 flush_i  in  1  jump flush; any in-flight or pending fetch result is discarded.
REQ-009 bus_req_o / bus_we_o / bus_addr_o / bus_wdata_o  out  1 / 1 / ADDR_WIDTH / DATA_WIDTH  shared memory port, all registered.
REQ-010 bus_ack_i / bus_rdata_i  in  1 / DATA_WIDTH  access complete; rdata valid with ack.
REQ-011 if_valid_o / if_rdata_o  out  1 / DATA_WIDTH  one-cycle fetch completion pulse and data.
REQ-012 mem_valid_o / mem_rdata_o  out  1 / DATA_WIDTH  one-cycle load/store completion pulse and data.
REQ-013 stallreq_from_if_o / stallreq_from_mem_o  out  1 / 1  stall requests to the pipeline controller.
REQ-014 err_o  out  1  one-cycle pulse on bus timeout.

Function
REQ-015 FSM states SHALL be IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-016 IDLE: mem_req_i SHALL win over if_req_i (MEM priority) -> MEM_BUSY; else if_req_i with flush_i low -> IF_BUSY; else stay.
REQ-017 On grant, address/we/wdata SHALL be latched; bus_req_o high from next cycle, bus_* held stable until ack or abort.
REQ-018 IF grant SHALL drive bus_we_o low and bus_wdata_o zero.
REQ-019 BUSY with bus_ack_i high: rdata registered, bus_req_o low next cycle, -> DONE; matching valid_o high for the DONE cycle only.
REQ-020 DONE SHALL last exactly one cycle, grant nothing, -> IDLE.
REQ-021 Minimum latency: req at cycle 0, bus_req_o cycle 1, ack cycle 1, valid_o cycle 2; max throughput one access per 3 cycles.
REQ-022 Wait counter (8 bits) SHALL clear on grant and increment each BUSY cycle without ack; at count TIMEOUT-1 without ack: err_o pulses next cycle, bus_req_o drops, -> IDLE, no valid_o.
REQ-023 Ack in the same cycle the counter reaches TIMEOUT-1 SHALL complete normally (ack wins, no err_o).
REQ-024 flush_i in IF_BUSY SHALL set a discard flag; the eventual ack/timeout completes the bus cycle but suppresses if_valid_o; flag cleared on leaving IF_BUSY.
REQ-025 flush_i in the ack cycle or in DONE SHALL suppress if_valid_o.
REQ-026 flush_i SHALL NOT affect MEM_BUSY or mem_valid_o.
REQ-027 stallreq_from_if_o = if_req_i AND NOT if_valid_o (combinational); same rule for mem.
REQ-028 if_rdata_o / mem_rdata_o SHALL hold last value between completions.
REQ-029 bus_ack_i in IDLE or DONE SHALL be ignored.

Reset
REQ-030 rst_i high SHALL immediately force IDLE, counter 0, discard flag 0, all bus_* / valid / err outputs 0, rdata 0; stall outputs follow REQ-027.
REQ-031 Reset mid-access SHALL drop bus_req_o asynchronously; a later ack SHALL be ignored.

Verification
REQ-032 Fetch: if_req_i=1, if_addr_i=0x100, ack after 3 cycles with rdata 0x00000013 -> bus_addr_o=0x100, bus_we_o=0, if_valid_o one cycle after ack, if_rdata_o=0x13.
REQ-033 Contention: if_req_i and mem_req_i (we=1, addr 0x2000, wdata 0xDEADBEEF) both rise at cycle 0 -> store issued first, mem_valid_o then fetch grant in cycle after DONE; stallreq_from_if_o high throughout.
REQ-034 Flush: flush_i pulse during IF_BUSY, ack 2 cycles later -> no if_valid_o, FSM returns IDLE via DONE.
REQ-035 Timeout: TIMEOUT=4, no ack -> bus_req_o high 4 cycles, err_o pulse, no valid, then new grant possible.
REQ-036 Boundary: ack on final timeout cycle -> valid, no err_o; rst_i asserted mid MEM_BUSY -> bus_req_o low same cycle, late ack ignored.
